rtc_hms_core: RTL
=================

Name: rtc_hms_core

Overview:
Parametrised real-time-clock core: a prescaler produces a 1 Hz tick that drives seconds/minutes/hours counters.
Adds run/stop, field-wise time setting, parallel load, 12/24 h display mode and a daily alarm.
Sits between the board clock input and the segment display driver.
Binary time and display-ready hour/PM outputs feed the display mux.

Parameters:
PRESCALE, 65536, clk cycles per second; legal range 2..2^24; prescaler width is clog2(PRESCALE).
ALARM_EN_DEFAULT, 0, reset value of the alarm-armed flag.

Ports:
clk  in  1  single clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
run  in  1  1 = time advances; 0 = prescaler and counters hold
set_sel  in  2  0 none, 1 second, 2 minute, 3 hour; nonzero suspends counting
set_inc  in  1  level sampled each cycle; +1 to the selected field
load  in  1  parallel load of time from ld_*
ld_hour  in  5  load value, 0..23
ld_min  in  6  load value, 0..59
ld_sec  in  6  load value, 0..59
mode_12h  in  1  display format select
alarm_wr  in  1  captures alarm_hour/alarm_min
alarm_hour  in  5  0..23
alarm_min  in  6  0..59
alarm_arm  in  1  sampled with alarm_wr; sets the armed flag
hour  out  5  0..23
minute  out  6  0..59
second  out  6  0..59
hour_disp  out  5  24h mode = hour; 12h mode = 12 for hour 0/12, else hour mod 12
pm  out  1  hour >= 12, valid in both modes
sec_tick  out  1  1-cycle pulse, seconds advanced by counting
min_tick  out  1  1-cycle pulse, seconds wrapped 59->0
hour_tick  out  1  1-cycle pulse, minutes wrapped 59->0
day_tick  out  1  1-cycle pulse, 23:59:59 -> 00:00:00
alarm_hit  out  1  1-cycle pulse on alarm match

Behaviour:
- Reset, asynchronous: prescaler 0; time 00:00:00; alarm 00:00; armed = ALARM_EN_DEFAULT; all pulses 0. Outputs are combinational from regs: hour_disp 12, pm 0.
- Counting is enabled when run=1 and set_sel=0 and load=0.
- Prescaler counts 0..PRESCALE-1 and wraps. Internal tick fires in the cycle the count equals PRESCALE-1 and counting is enabled.
- When counting is disabled, the prescaler holds its value.
- Tick cycle: second+1. At 59 it wraps to 0 and minute+1, with cascade to hour. Hour 23 wraps to 0.
- All changes are registered. Each *_tick output is registered and asserts in the same cycle the new time is visible.
- Priority, highest first: load > set_inc > counting.
- load:
  - time <- ld_* next cycle; prescaler cleared to 0; no tick pulses.
  - Any out-of-range ld field (hour>23, min/sec>59) loads 0 for that field only.
- set_inc with set_sel!=0:
  - Selected field +1, wrapping within its own range (59->0, 23->0).
  - No carry into other fields; no tick pulses; prescaler held.
  - set_inc with set_sel=0 is ignored.
- alarm_wr: captures alarm_hour/alarm_min (out-of-range -> 0) and alarm_arm.
  - Takes effect next cycle. It may coincide with any other input.
- alarm_hit:
  - Asserts in the cycle min_tick asserts when armed=1 and the new hour:minute equals the stored alarm.
  - Does not fire on load or set_inc reaching the alarm time.
  - The armed flag stays set.
- The tick pulses coincide: day_tick implies hour_tick implies min_tick implies sec_tick.
- rst_n low mid-count aborts immediately. No pulse is emitted after release until a full PRESCALE period elapses.

Decomposition:
- Shared package rtc_pkg holds:
  - Field widths HOUR_W=5 and MIN_W=SEC_W=6.
  - Limits SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23.
  - set_sel encodings SEL_NONE/SEL_SEC/SEL_MIN/SEL_HOUR.
- One sub-module, rtc_prescaler: parametrised modulo-PRESCALE counter with enable and synchronous clear; outputs the terminal-count tick.
- Field counters and the 12h conversion stay inline in rtc_hms_core.

Test Plan:
- PRESCALE=4, run=1 from reset -> first sec_tick on cycle 4 after reset release, second=1; pulse every 4 cycles thereafter.
- load 23:59:58, run 8 cycles -> at cycle 4 second=59; at cycle 8 time 00:00:00 with sec/min/hour/day_tick all high for one cycle.
- set_sel=2 with minute=59, one set_inc cycle -> minute=0, hour unchanged, no ticks; prescaler value unchanged across the set period.
- alarm_wr 07:30 with arm=1, load 07:29:59, run -> alarm_hit with the next min_tick. A load to 07:30:00 -> no alarm_hit.
- mode_12h=1: hour 0 -> hour_disp 12, pm 0; hour 12 -> 12, pm 1; hour 13 -> 1, pm 1. mode_12h=0, hour 13 -> hour_disp 13.
- load ld_min=60 -> minute=0, other fields loaded. rst_n pulsed mid-period -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/rtc_hms_core_pkg.sv
// Shared field widths, limits and set-select encodings for the RTC core.
package rtc_pkg;

  localparam int unsigned HOUR_W = 5;
  localparam int unsigned MIN_W  = 6;
  localparam int unsigned SEC_W  = 6;

  localparam logic [SEC_W-1:0]  SEC_MAX  = SEC_W'(59);
  localparam logic [MIN_W-1:0]  MIN_MAX  = MIN_W'(59);
  localparam logic [HOUR_W-1:0] HOUR_MAX = HOUR_W'(23);

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_SEC  = 2'd1,
    SEL_MIN  = 2'd2,
    SEL_HOUR = 2'd3
  } set_sel_e;

endpackage

// File: rtl/rtc_hms_core_if.sv
// Control, load, alarm and time/display signals of the RTC core.
interface rtc_hms_if;
  import rtc_pkg::*;

  logic              run;
  logic [1:0]        set_sel;
  logic              set_inc;
  logic              load;
  logic [HOUR_W-1:0] ld_hour;
  logic [MIN_W-1:0]  ld_min;
  logic [SEC_W-1:0]  ld_sec;
  logic              mode_12h;
  logic              alarm_wr;
  logic [HOUR_W-1:0] alarm_hour;
  logic [MIN_W-1:0]  alarm_min;
  logic              alarm_arm;

  logic [HOUR_W-1:0] hour;
  logic [MIN_W-1:0]  minute;
  logic [SEC_W-1:0]  second;
  logic [HOUR_W-1:0] hour_disp;
  logic              pm;
  logic              sec_tick;
  logic              min_tick;
  logic              hour_tick;
  logic              day_tick;
  logic              alarm_hit;

  modport master (
    output run, set_sel, set_inc, load, ld_hour, ld_min, ld_sec, mode_12h,
           alarm_wr, alarm_hour, alarm_min, alarm_arm,
    input  hour, minute, second, hour_disp, pm,
           sec_tick, min_tick, hour_tick, day_tick, alarm_hit
  );

  modport slave (
    input  run, set_sel, set_inc, load, ld_hour, ld_min, ld_sec, mode_12h,
           alarm_wr, alarm_hour, alarm_min, alarm_arm,
    output hour, minute, second, hour_disp, pm,
           sec_tick, min_tick, hour_tick, day_tick, alarm_hit
  );

endinterface

// File: rtl/rtc_hms_core_prescaler.sv
// Modulo-PRESCALE counter with enable and synchronous clear; tick at terminal count.
module rtc_prescaler #(
  parameter int unsigned PRESCALE = 65536
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned W = $clog2(PRESCALE);
  localparam logic [W-1:0] TERM = W'(PRESCALE - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == TERM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == TERM) ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/rtc_hms_core.sv
// Real-time-clock core: hh:mm:ss counters with set/load, 12/24h display and daily alarm.
module rtc_hms_core
  import rtc_pkg::*;
#(
  parameter int unsigned PRESCALE         = 65536,
  parameter bit          ALARM_EN_DEFAULT = 1'b0
) (
  input logic       clk,
  input logic       rst_n,
  rtc_hms_if.slave  bus
);

  logic [HOUR_W-1:0] hour_q, hour_inc, nxt_hour, al_hour_q;
  logic [MIN_W-1:0]  min_q, min_inc, al_min_q;
  logic [SEC_W-1:0]  sec_q, sec_inc;
  logic              armed_q;
  logic              sec_wrap, min_wrap, hour_wrap;
  logic              count_en, tick;
  set_sel_e          sel;

  logic [HOUR_W-1:0] ld_hour_c, al_hour_c;
  logic [MIN_W-1:0]  ld_min_c, al_min_c;
  logic [SEC_W-1:0]  ld_sec_c;

  always_comb begin
    sel       = set_sel_e'(bus.set_sel);
    count_en  = bus.run && (sel == SEL_NONE) && !bus.load;
    sec_wrap  = (sec_q == SEC_MAX);
    min_wrap  = (min_q == MIN_MAX);
    hour_wrap = (hour_q == HOUR_MAX);
    sec_inc   = sec_wrap  ? '0 : sec_q + SEC_W'(1);
    min_inc   = min_wrap  ? '0 : min_q + MIN_W'(1);
    hour_inc  = hour_wrap ? '0 : hour_q + HOUR_W'(1);
    // hour value after a minute rollover, for alarm comparison against the new time
    nxt_hour  = min_wrap ? hour_inc : hour_q;
    ld_hour_c = (bus.ld_hour > HOUR_MAX)    ? '0 : bus.ld_hour;
    ld_min_c  = (bus.ld_min  > MIN_MAX)     ? '0 : bus.ld_min;
    ld_sec_c  = (bus.ld_sec  > SEC_MAX)     ? '0 : bus.ld_sec;
    al_hour_c = (bus.alarm_hour > HOUR_MAX) ? '0 : bus.alarm_hour;
    al_min_c  = (bus.alarm_min  > MIN_MAX)  ? '0 : bus.alarm_min;
  end

  rtc_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (count_en),
    .clr   (bus.load),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hour_q        <= '0;
      min_q         <= '0;
      sec_q         <= '0;
      bus.sec_tick  <= 1'b0;
      bus.min_tick  <= 1'b0;
      bus.hour_tick <= 1'b0;
      bus.day_tick  <= 1'b0;
      bus.alarm_hit <= 1'b0;
    end else begin
      bus.sec_tick  <= 1'b0;
      bus.min_tick  <= 1'b0;
      bus.hour_tick <= 1'b0;
      bus.day_tick  <= 1'b0;
      bus.alarm_hit <= 1'b0;
      if (bus.load) begin
        hour_q <= ld_hour_c;
        min_q  <= ld_min_c;
        sec_q  <= ld_sec_c;
      end else if (sel != SEL_NONE) begin
        if (bus.set_inc) begin
          case (sel)
            SEL_SEC:  sec_q  <= sec_inc;
            SEL_MIN:  min_q  <= min_inc;
            SEL_HOUR: hour_q <= hour_inc;
            default:  ;
          endcase
        end
      end else if (tick) begin
        sec_q         <= sec_inc;
        bus.sec_tick  <= 1'b1;
        if (sec_wrap) begin
          min_q        <= min_inc;
          bus.min_tick <= 1'b1;
          bus.alarm_hit <= armed_q && (min_inc == al_min_q) && (nxt_hour == al_hour_q);
          if (min_wrap) begin
            hour_q        <= hour_inc;
            bus.hour_tick <= 1'b1;
            bus.day_tick  <= hour_wrap;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      al_hour_q <= '0;
      al_min_q  <= '0;
      armed_q   <= ALARM_EN_DEFAULT;
    end else if (bus.alarm_wr) begin
      al_hour_q <= al_hour_c;
      al_min_q  <= al_min_c;
      armed_q   <= bus.alarm_arm;
    end
  end

  always_comb begin
    bus.hour   = hour_q;
    bus.minute = min_q;
    bus.second = sec_q;
    bus.pm     = (hour_q >= HOUR_W'(12));
    if (!bus.mode_12h)
      bus.hour_disp = hour_q;
    else if (hour_q == '0)
      bus.hour_disp = HOUR_W'(12);
    else if (hour_q > HOUR_W'(12))
      bus.hour_disp = hour_q - HOUR_W'(12);
    else
      bus.hour_disp = hour_q;
  end

endmodule
